pixel_scan_gen: RTL and testbench

- Parametrised frame scanner that issues one pixel work token per accepted handshake to the Mandelbrot solver array.
- Walks a W x H frame in raster order and assigns whole lines to solvers round-robin.
- Emits linear framebuffer address, x/y coordinates and stream framing flags (sof/eol/eof).
- Successor of the free-running VGA iterator: adds valid/ready backpressure, start/done control, single or continuous frame mode, and generic resolution.

---
 rtl/fractal_pkg.sv | 13 +
 rtl/pixel_scan_gen_scan_counter.sv | 78 +++++++
 rtl/pixel_scan_gen.sv | 189 ++++++++++++++++++
 tb/tb_pixel_scan_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal pipeline: default frame geometry and scan states.
package fractal_pkg;

  localparam int H_RES_DEF  = 640;
  localparam int V_RES_DEF  = 480;
  localparam int ADDR_W_DEF = 19;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/pixel_scan_gen_scan_counter.sv
// Raster x/y/address counter with programmable bounds and line jump.
// Priority: clear > load > advance; advancing past the last pixel reloads the first one.
module scan_counter #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              advance,
  input  logic [X_W-1:0]    x_first,
  input  logic [X_W-1:0]    x_last,
  input  logic [Y_W-1:0]    y_first,
  input  logic [Y_W-1:0]    y_last,
  input  logic [ADDR_W-1:0] addr_first,
  input  logic [ADDR_W-1:0] line_jump,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              x_at_last,
  output logic              y_at_last
);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign x_at_last = (x_q == x_last);
  assign y_at_last = (y_q == y_last);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (load) begin
      x_d    = x_first;
      y_d    = y_first;
      addr_d = addr_first;
    end else if (advance) begin
      if (!x_at_last) begin
        x_d    = x_q + X_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end else if (!y_at_last) begin
        // line_jump skips the columns outside the scanned window
        x_d    = x_first;
        y_d    = y_q + Y_W'(1);
        addr_d = addr_q + line_jump;
      end else begin
        x_d    = x_first;
        y_d    = y_first;
        addr_d = addr_first;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = addr_q;

endmodule

// File: rtl/pixel_scan_gen.sv
// Frame scanner issuing one pixel token per valid/ready handshake, lines dealt round-robin to solvers.
// Optional region-of-interest scan is enabled by defining PIXEL_SCAN_ROI_EN.
module pixel_scan_gen
  import fractal_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int NUM_SOLVERS = 1,
  parameter int ID_W        = 6,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int X_W         = 10,
  parameter int Y_W         = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
`ifdef PIXEL_SCAN_ROI_EN
  input  logic [X_W-1:0]    roi_x0,
  input  logic [X_W-1:0]    roi_x1,
  input  logic [Y_W-1:0]    roi_y0,
  input  logic [Y_W-1:0]    roi_y1,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   solver_id,
  output logic [ADDR_W-1:0] solver_addr,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              frame_done
);

  scan_state_t     state_q, state_d;
  logic            cont_q, cont_d;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            done_q, done_d;

  logic              cnt_clear, cnt_load, cnt_advance;
  logic              x_at_last, y_at_last;
  logic [X_W-1:0]    bnd_x0, bnd_x1;
  logic [Y_W-1:0]    bnd_y0, bnd_y1;
  logic [ADDR_W-1:0] addr_first, line_jump;
  logic              start_ok;

`ifdef PIXEL_SCAN_ROI_EN
  logic [X_W-1:0] roi_x0_q, roi_x1_q;
  logic [Y_W-1:0] roi_y0_q, roi_y1_q;
  logic           roi_ok;

  assign roi_ok   = (roi_x0 <= roi_x1) && (roi_y0 <= roi_y1);
  assign start_ok = start && roi_ok && (state_q == SCAN_IDLE);

  // While idle the live inputs feed the first load; afterwards the latched window is used.
  assign bnd_x0 = (state_q == SCAN_IDLE) ? roi_x0 : roi_x0_q;
  assign bnd_x1 = (state_q == SCAN_IDLE) ? roi_x1 : roi_x1_q;
  assign bnd_y0 = (state_q == SCAN_IDLE) ? roi_y0 : roi_y0_q;
  assign bnd_y1 = (state_q == SCAN_IDLE) ? roi_y1 : roi_y1_q;

  // H_RES is a constant, so the base offset reduces to shifts and adds.
  assign addr_first = ADDR_W'(bnd_y0) * ADDR_W'(H_RES) + ADDR_W'(bnd_x0);
  assign line_jump  = ADDR_W'(H_RES) - ADDR_W'(bnd_x1) + ADDR_W'(bnd_x0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      roi_x0_q <= '0;
      roi_x1_q <= '0;
      roi_y0_q <= '0;
      roi_y1_q <= '0;
    end else if (start_ok && !abort) begin
      roi_x0_q <= roi_x0;
      roi_x1_q <= roi_x1;
      roi_y0_q <= roi_y0;
      roi_y1_q <= roi_y1;
    end
  end
`else
  assign start_ok   = start && (state_q == SCAN_IDLE);
  assign bnd_x0     = '0;
  assign bnd_x1     = X_W'(H_RES - 1);
  assign bnd_y0     = '0;
  assign bnd_y1     = Y_W'(V_RES - 1);
  assign addr_first = '0;
  assign line_jump  = ADDR_W'(1);
`endif

  scan_counter #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .advance    (cnt_advance),
    .x_first    (bnd_x0),
    .x_last     (bnd_x1),
    .y_first    (bnd_y0),
    .y_last     (bnd_y1),
    .addr_first (addr_first),
    .line_jump  (line_jump),
    .x          (pix_x),
    .y          (pix_y),
    .addr       (solver_addr),
    .x_at_last  (x_at_last),
    .y_at_last  (y_at_last)
  );

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    valid_d     = valid_q;
    id_d        = id_q;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    cnt_advance = 1'b0;
    if (abort) begin
      state_d   = SCAN_IDLE;
      cont_d    = 1'b0;
      valid_d   = 1'b0;
      id_d      = '0;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        SCAN_IDLE: begin
          if (start_ok) begin
            state_d  = SCAN_RUN;
            cont_d   = continuous;
            valid_d  = 1'b1;
            id_d     = '0;
            cnt_load = 1'b1;
          end
        end
        default: begin
          if (valid_q && out_ready) begin
            if (x_at_last && y_at_last) begin
              done_d = 1'b1;
              id_d   = '0;
              if (cont_q) begin
                cnt_load = 1'b1;
              end else begin
                state_d   = SCAN_IDLE;
                valid_d   = 1'b0;
                cnt_clear = 1'b1;
              end
            end else begin
              cnt_advance = 1'b1;
              if (x_at_last) begin
                id_d = (id_q == ID_W'(NUM_SOLVERS - 1)) ? '0 : id_q + ID_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SCAN_IDLE;
      cont_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = valid_q;
  assign solver_id  = id_q;
  assign busy       = (state_q != SCAN_IDLE);
  assign frame_done = done_q;
  assign sof        = valid_q && (pix_x == bnd_x0) && (pix_y == bnd_y0);
  assign eol        = valid_q && x_at_last;
  assign eof        = valid_q && x_at_last && y_at_last;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed bench for pixel_scan_gen on a 4x3 frame with two solvers; ROI case under PIXEL_SCAN_ROI_EN.
module tb_pixel_scan_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, continuous, abort, out_ready;
  logic       out_valid, sof, eol, eof, busy, frame_done;
  logic [1:0] solver_id;
  logic [3:0] solver_addr;
  logic [1:0] pix_x;
  logic [1:0] pix_y;
`ifdef PIXEL_SCAN_ROI_EN
  logic [1:0] roi_x0, roi_x1, roi_y0, roi_y1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pixel_scan_gen #(
    .H_RES(4), .V_RES(3), .NUM_SOLVERS(2), .ID_W(2), .ADDR_W(4), .X_W(2), .Y_W(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .abort       (abort),
`ifdef PIXEL_SCAN_ROI_EN
    .roi_x0      (roi_x0),
    .roi_x1      (roi_x1),
    .roi_y0      (roi_y0),
    .roi_y1      (roi_y1),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .solver_id   (solver_id),
    .solver_addr (solver_addr),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .sof         (sof),
    .eol         (eol),
    .eof         (eof),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic st, co, ab, rd;
    logic valid;
    int   addr;
    int   id;
    logic sof, eol, eof, busy, done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== exp[31:0]) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  // Token expected after the edge; a full-frame address fixes x, y, line and flags.
  task automatic add_tok(input logic st, co, ab, rd, input int a, input logic dn);
    vec_t v;
    v.st = st; v.co = co; v.ab = ab; v.rd = rd;
    v.valid = 1'b1; v.addr = a; v.id = (a / 4) % 2;
    v.sof = (a == 0); v.eol = (a % 4 == 3); v.eof = (a == 11);
    v.busy = 1'b1; v.done = dn;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input logic st, co, ab, rd, input logic dn);
    vec_t v;
    v.st = st; v.co = co; v.ab = ab; v.rd = rd;
    v.valid = 1'b0; v.addr = 0; v.id = 0;
    v.sof = 1'b0; v.eol = 1'b0; v.eof = 1'b0;
    v.busy = 1'b0; v.done = dn;
    tbl.push_back(v);
  endtask

  initial begin
    int exp_a, acc, cyc;
    logic rd;

    // single frame, ready held high; start on the final accept must be ignored
    add_tok(1, 0, 0, 1, 0, 0);
    for (int a = 1; a < 12; a++) add_tok(0, 0, 0, 1, a, 0);
    add_idle(1, 0, 0, 1, 1);
    add_idle(0, 0, 0, 1, 0);
    // start mid-frame ignored, abort+start at addr 5, restart at 0
    add_tok(1, 0, 0, 1, 0, 0);
    add_tok(0, 0, 0, 1, 1, 0);
    add_tok(0, 0, 0, 1, 2, 0);
    add_tok(1, 0, 0, 1, 3, 0);
    add_tok(0, 0, 0, 1, 4, 0);
    add_tok(0, 0, 0, 1, 5, 0);
    add_idle(1, 0, 1, 1, 0);
    add_idle(0, 0, 0, 1, 0);
    add_tok(1, 0, 0, 1, 0, 0);
    add_idle(0, 0, 1, 1, 0);
    // continuous mode: continuous only sampled at start
    add_tok(1, 1, 0, 1, 0, 0);
    for (int n = 1; n < 26; n++) add_tok(0, 0, 0, 1, n % 12, (n % 12) == 0);
    add_idle(0, 0, 1, 1, 0);

    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; out_ready = 1'b0;
`ifdef PIXEL_SCAN_ROI_EN
    roi_x0 = 2'd0; roi_x1 = 2'd3; roi_y0 = 2'd0; roi_y1 = 2'd2;
`endif
    @(negedge clock);
    @(negedge clock);
    chk("reset valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", frame_done, 0);
    chk("reset addr", solver_addr, 0);
    chk("reset sof", sof, 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      start = tbl[i].st; continuous = tbl[i].co; abort = tbl[i].ab; out_ready = tbl[i].rd;
      @(posedge clock);
      #1;
      chk($sformatf("row%0d valid", i), out_valid, tbl[i].valid);
      chk($sformatf("row%0d addr", i), solver_addr, tbl[i].addr);
      chk($sformatf("row%0d x", i), pix_x, tbl[i].addr % 4);
      chk($sformatf("row%0d y", i), pix_y, tbl[i].addr / 4);
      chk($sformatf("row%0d id", i), solver_id, tbl[i].id);
      chk($sformatf("row%0d sof", i), sof, tbl[i].sof);
      chk($sformatf("row%0d eol", i), eol, tbl[i].eol);
      chk($sformatf("row%0d eof", i), eof, tbl[i].eof);
      chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d done", i), frame_done, tbl[i].done);
    end
    @(negedge clock);
    start = 1'b0; abort = 1'b0; continuous = 1'b0; out_ready = 1'b0;

    // backpressure: ready pattern 1,0,0,1; token must hold through stalls
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    exp_a = 0; acc = 0; cyc = 0;
    while (acc < 12 && cyc < 100) begin
      @(negedge clock);
      rd = (cyc % 4 == 0) || (cyc % 4 == 3);
      chk("stall valid", out_valid, 1);
      chk("stall addr", solver_addr, exp_a);
      chk("stall eol", eol, (exp_a % 4) == 3);
      chk("stall done", frame_done, 0);
      out_ready = rd;
      if (rd) begin
        acc++;
        exp_a++;
      end
      cyc++;
    end
    @(negedge clock);
    chk("stall accepts", acc, 12);
    chk("stall frame_done", frame_done, 1);
    chk("stall end valid", out_valid, 0);

    // asynchronous reset while token 7 is presented
    start = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    chk("pre-reset addr", solver_addr, 7);
    reset = 1'b1;
    #1;
    chk("async valid", out_valid, 0);
    chk("async busy", busy, 0);
    chk("async addr", solver_addr, 0);
    chk("async id", solver_id, 0);
    chk("async eol", eol, 0);
    @(negedge clock);
    reset = 1'b0;
    chk("post-reset valid", out_valid, 0);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("restart addr", solver_addr, 0);
    chk("restart sof", sof, 1);
    repeat (11) @(posedge clock);
    #1;
    chk("restart last addr", solver_addr, 11);
    chk("restart eof", eof, 1);
    @(posedge clock);
    #1;
    chk("restart done", frame_done, 1);
    chk("restart idle", out_valid, 0);

`ifdef PIXEL_SCAN_ROI_EN
    begin
      int roi_a[4]   = '{5, 6, 9, 10};
      int roi_id[4]  = '{0, 0, 1, 1};
      @(negedge clock);
      roi_x0 = 2'd1; roi_x1 = 2'd2; roi_y0 = 2'd1; roi_y1 = 2'd2;
      start = 1'b1; out_ready = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin
          @(posedge clock);
          #1;
        end
        chk("roi valid", out_valid, 1);
        chk("roi addr", solver_addr, roi_a[k]);
        chk("roi id", solver_id, roi_id[k]);
        chk("roi sof", sof, k == 0);
        chk("roi eol", eol, (k % 2) == 1);
        chk("roi eof", eof, k == 3);
      end
      @(posedge clock);
      #1;
      chk("roi done", frame_done, 1);
      chk("roi idle", out_valid, 0);
      @(negedge clock);
      roi_x0 = 2'd3; roi_x1 = 2'd1;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      chk("roi bad start valid", out_valid, 0);
      chk("roi bad start busy", busy, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
